// File: rtl/ref_mer_measure.sv
// Reference-level and MER measurement: per-window I/Q level estimate, squared
// error of filtered samples against re-mapped 4-ASK decisions, and mapper power.
module ref_mer_measure #(
    parameter int DATA_W       = 18,
    parameter int LOG2_WIN_MAX = 20,
    parameter int REF_INIT     = 1460
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   sym_clk_ena,
    input  logic                                   meas_en,
    input  logic [4:0]                             log2_win,
    input  logic signed [DATA_W-1:0]               recovered_i,
    input  logic signed [DATA_W-1:0]               recovered_q,
    input  logic [1:0]                             syms_i,
    input  logic [1:0]                             syms_q,
    input  logic signed [DATA_W-1:0]               filt_out_i,
    input  logic signed [DATA_W-1:0]               filt_out_q,
    output logic signed [DATA_W-1:0]               measured_ref_i,
    output logic signed [DATA_W-1:0]               measured_ref_q,
    output logic [2*DATA_W:0]                      mapper_output_power_i,
    output logic [2*DATA_W:0]                      mapper_output_power_q,
    output logic [2*DATA_W+1+LOG2_WIN_MAX:0]       accumulated_square_error_i,
    output logic [2*DATA_W+1+LOG2_WIN_MAX:0]       accumulated_square_error_q,
    output logic                                   meas_valid,
    output logic [15:0]                            window_count,
    output logic [1:0]                             o_dbg_state
);
    localparam int AW = DATA_W + LOG2_WIN_MAX;
    localparam int PW = 2 * DATA_W + 1;
    localparam int SW = 2 * DATA_W + 2;
    localparam int EW = 2 * DATA_W + 2 + LOG2_WIN_MAX;
    localparam int CW = LOG2_WIN_MAX;
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2} state_t;

    state_t                   r_state;
    logic [4:0]               r_k;
    logic [CW-1:0]            r_cnt;
    logic [AW-1:0]            r_lvl_i, r_lvl_q;
    logic [EW-1:0]            r_err_i, r_err_q;
    logic signed [DATA_W-1:0] r_ref_i, r_ref_q;
    logic [PW-1:0]            r_pwr_i, r_pwr_q;
    logic [EW-1:0]            r_ase_i, r_ase_q;
    logic                     r_valid;
    logic [15:0]              r_wcnt;

    logic [DATA_W-1:0]        w_mag_i, w_mag_q;
    logic [AW-1:0]            w_lvl_sum_i, w_lvl_sum_q;
    logic [EW-1:0]            w_err_sum_i, w_err_sum_q;
    logic                     w_last;

    function automatic logic [4:0] f_clamp(input logic [4:0] k);
        if (k < 5'd2) return 5'd2;
        if (int'(k) > LOG2_WIN_MAX) return 5'(LOG2_WIN_MAX);
        return k;
    endfunction

    // The most negative code has no positive twin, so it saturates.
    function automatic logic [DATA_W-1:0] f_mag(input logic [DATA_W-1:0] x);
        if (x == MOST_NEG) return ~MOST_NEG;
        if (x[DATA_W-1]) return -x;
        return x;
    endfunction

    function automatic logic signed [DATA_W:0] f_remap(input logic signed [DATA_W-1:0] r,
                                                        input logic [1:0] s);
        logic signed [DATA_W:0] w_r, w_h, w_rh;
        w_r  = {r[DATA_W-1], r};
        w_h  = w_r >>> 1;
        w_rh = w_r + w_h;
        case (s)
            2'b00:   return -w_rh;
            2'b01:   return -w_h;
            2'b10:   return w_h;
            default: return w_rh;
        endcase
    endfunction

    function automatic logic [SW-1:0] f_esq(input logic signed [DATA_W-1:0] f,
                                            input logic signed [DATA_W:0] m);
        logic signed [DATA_W:0] w_e;
        logic signed [SW-1:0]   w_x;
        w_e = {f[DATA_W-1], f} - m;
        w_x = SW'(w_e);
        return w_x * w_x;
    endfunction

    function automatic logic [PW-1:0] f_power(input logic signed [DATA_W-1:0] r);
        logic signed [PW-1:0] w_r;
        logic [PW-1:0]        w_sq;
        w_r  = PW'(r);
        w_sq = w_r * w_r;
        return w_sq + (w_sq >> 2);
    endfunction

    // Window sums include the current strobe so a window-ending sample counts.
    assign w_mag_i     = f_mag(recovered_i);
    assign w_mag_q     = f_mag(recovered_q);
    assign w_lvl_sum_i = r_lvl_i + AW'(w_mag_i);
    assign w_lvl_sum_q = r_lvl_q + AW'(w_mag_q);
    assign w_err_sum_i = r_err_i + EW'(f_esq(filt_out_i, f_remap(r_ref_i, syms_i)));
    assign w_err_sum_q = r_err_q + EW'(f_esq(filt_out_q, f_remap(r_ref_q, syms_q)));
    assign w_last      = (r_cnt == CW'((32'd1 << r_k) - 32'd1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_k     <= 5'd2;
            r_cnt   <= '0;
            r_lvl_i <= '0;
            r_lvl_q <= '0;
            r_err_i <= '0;
            r_err_q <= '0;
            r_ref_i <= DATA_W'(REF_INIT);
            r_ref_q <= DATA_W'(REF_INIT);
            r_pwr_i <= '0;
            r_pwr_q <= '0;
            r_ase_i <= '0;
            r_ase_q <= '0;
            r_valid <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            r_valid <= 1'b0;
            r_pwr_i <= f_power(r_ref_i);
            r_pwr_q <= f_power(r_ref_q);
            if (!meas_en) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_lvl_i <= '0;
                r_lvl_q <= '0;
                r_err_i <= '0;
                r_err_q <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ACQ;
                        r_k     <= f_clamp(log2_win);
                    end
                    default: begin
                        if (sym_clk_ena) begin
                            if (w_last) begin
                                r_state <= TRACK;
                                r_k     <= f_clamp(log2_win);
                                r_ref_i <= DATA_W'(w_lvl_sum_i >> r_k);
                                r_ref_q <= DATA_W'(w_lvl_sum_q >> r_k);
                                r_ase_i <= w_err_sum_i;
                                r_ase_q <= w_err_sum_q;
                                r_valid <= 1'b1;
                                if (r_wcnt != 16'hFFFF) r_wcnt <= r_wcnt + 16'd1;
                                r_cnt   <= '0;
                                r_lvl_i <= '0;
                                r_lvl_q <= '0;
                                r_err_i <= '0;
                                r_err_q <= '0;
                            end else begin
                                r_cnt   <= r_cnt + CW'(1);
                                r_lvl_i <= w_lvl_sum_i;
                                r_lvl_q <= w_lvl_sum_q;
                                r_err_i <= w_err_sum_i;
                                r_err_q <= w_err_sum_q;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign measured_ref_i             = r_ref_i;
    assign measured_ref_q             = r_ref_q;
    assign mapper_output_power_i      = r_pwr_i;
    assign mapper_output_power_q      = r_pwr_q;
    assign accumulated_square_error_i = r_ase_i;
    assign accumulated_square_error_q = r_ase_q;
    assign meas_valid                 = r_valid;
    assign window_count               = r_wcnt;
    assign o_dbg_state                = r_state;
endmodule

// File: tb/tb_ref_mer_measure.sv
// Bench for ref_mer_measure: driver tasks feed strobes, a small model pushes
// expected window results to a queue that is popped on every meas_valid pulse.
module tb_ref_mer_measure;
    localparam int DW  = 18;
    localparam int LWM = 20;
    localparam int EW  = 2 * DW + 2 + LWM;
    localparam int PW  = 2 * DW + 1;

    logic                 clk = 1'b0;
    logic                 reset_n, sym_clk_ena, meas_en;
    logic [4:0]           log2_win;
    logic signed [DW-1:0] recovered_i, recovered_q, filt_out_i, filt_out_q;
    logic [1:0]           syms_i, syms_q;
    logic signed [DW-1:0] measured_ref_i, measured_ref_q;
    logic [PW-1:0]        mapper_output_power_i, mapper_output_power_q;
    logic [EW-1:0]        accumulated_square_error_i, accumulated_square_error_q;
    logic                 meas_valid;
    logic [15:0]          window_count;
    logic [1:0]           o_dbg_state;

    always #5 clk = ~clk;

    ref_mer_measure dut (
        .clk(clk), .reset_n(reset_n), .sym_clk_ena(sym_clk_ena), .meas_en(meas_en),
        .log2_win(log2_win), .recovered_i(recovered_i), .recovered_q(recovered_q),
        .syms_i(syms_i), .syms_q(syms_q), .filt_out_i(filt_out_i), .filt_out_q(filt_out_q),
        .measured_ref_i(measured_ref_i), .measured_ref_q(measured_ref_q),
        .mapper_output_power_i(mapper_output_power_i),
        .mapper_output_power_q(mapper_output_power_q),
        .accumulated_square_error_i(accumulated_square_error_i),
        .accumulated_square_error_q(accumulated_square_error_q),
        .meas_valid(meas_valid), .window_count(window_count), .o_dbg_state(o_dbg_state)
    );

    typedef struct {
        logic [DW-1:0] ref_i;
        logic [DW-1:0] ref_q;
        logic [EW-1:0] err_i;
        logic [EW-1:0] err_q;
        logic [15:0]   wc;
    } exp_t;

    exp_t    exp_q[$];
    int      n_pass = 0;
    int      n_total = 0;
    bit      prev_valid = 1'b0;
    bit      m_on = 1'b0;
    int      m_ref_i = 1460, m_ref_q = 1460, m_wc = 0, m_k = 2, m_cnt = 0;
    longint  m_lvl_i = 0, m_lvl_q = 0, m_err_i = 0, m_err_q = 0;

    // ---------------- model ----------------
    function automatic int clamp_k(input int k);
        if (k < 2) return 2;
        if (k > LWM) return LWM;
        return k;
    endfunction

    function automatic int mag(input int x);
        if (x == -131072) return 131071;
        return (x < 0) ? -x : x;
    endfunction

    function automatic int remap(input int r, input int s);
        int h;
        h = r >>> 1;
        case (s & 3)
            0:       return -(r + h);
            1:       return -h;
            2:       return h;
            default: return r + h;
        endcase
    endfunction

    function automatic longint esq(input int f, input int m);
        int e;
        e = (f - m) & 32'h7FFFF;
        if (e >= 32'h40000) e = e - 32'h80000;
        return longint'(e) * longint'(e);
    endfunction

    function automatic longint pwr(input int r);
        longint s;
        s = longint'(r) * longint'(r);
        return s + (s >> 2);
    endfunction

    task automatic model_clear();
        m_lvl_i = 0; m_lvl_q = 0; m_err_i = 0; m_err_q = 0; m_cnt = 0;
    endtask

    // ---------------- clock advance + scoreboard pop ----------------
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (meas_valid === 1'b1) begin
            n_total++;
            if (prev_valid) $display("FAIL valid_pulse got high 2 cycles exp 1 cycle");
            else n_pass++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_publish got meas_valid=1 exp no publish (wc=%0d)", window_count);
            end else begin
                n_pass++;
                e = exp_q.pop_front();
                n_total++;
                if (measured_ref_i !== e.ref_i) $display("FAIL pub_ref_i got %0d exp %0d", measured_ref_i, e.ref_i);
                else n_pass++;
                n_total++;
                if (measured_ref_q !== e.ref_q) $display("FAIL pub_ref_q got %0d exp %0d", measured_ref_q, e.ref_q);
                else n_pass++;
                n_total++;
                if (accumulated_square_error_i !== e.err_i) $display("FAIL pub_err_i got %0d exp %0d", accumulated_square_error_i, e.err_i);
                else n_pass++;
                n_total++;
                if (accumulated_square_error_q !== e.err_q) $display("FAIL pub_err_q got %0d exp %0d", accumulated_square_error_q, e.err_q);
                else n_pass++;
                n_total++;
                if (window_count !== e.wc) $display("FAIL pub_wc got %0d exp %0d", window_count, e.wc);
                else n_pass++;
            end
        end
        prev_valid = (meas_valid === 1'b1);
    endtask

    // ---------------- drivers ----------------
    task automatic do_strobe(input int ri, input int rq, input int si, input int sq,
                             input int fi, input int fq, input bit drop);
        exp_t e;
        recovered_i = DW'(ri); recovered_q = DW'(rq);
        syms_i = 2'(si);       syms_q = 2'(sq);
        filt_out_i = DW'(fi);  filt_out_q = DW'(fq);
        sym_clk_ena = 1'b1;
        if (drop) begin
            meas_en = 1'b0;
            m_on = 1'b0;
            model_clear();
        end else if (m_on) begin
            m_lvl_i += mag(ri);
            m_lvl_q += mag(rq);
            m_err_i += esq(fi, remap(m_ref_i, si));
            m_err_q += esq(fq, remap(m_ref_q, sq));
            if (m_cnt == (1 << m_k) - 1) begin
                e.ref_i = DW'(m_lvl_i >> m_k);
                e.ref_q = DW'(m_lvl_q >> m_k);
                e.err_i = EW'(m_err_i);
                e.err_q = EW'(m_err_q);
                if (m_wc < 65535) m_wc++;
                e.wc = 16'(m_wc);
                exp_q.push_back(e);
                m_ref_i = int'(m_lvl_i >> m_k);
                m_ref_q = int'(m_lvl_q >> m_k);
                model_clear();
                m_k = clamp_k(int'(log2_win));
            end else begin
                m_cnt++;
            end
        end
        cycle();
        sym_clk_ena = 1'b0;
    endtask

    task automatic rand_strobe(input int gap_max);
        int ri, rq;
        ri = $urandom_range(3000, 0) - 1500;
        rq = $urandom_range(3000, 0) - 1500;
        do_strobe(ri, rq, $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(4000, 0) - 2000, $urandom_range(4000, 0) - 2000, 1'b0);
        repeat ($urandom_range(gap_max, 0)) cycle();
    endtask

    task automatic enable(input int k);
        log2_win = 5'(k);
        meas_en = 1'b1;
        m_on = 1'b1;
        m_k = clamp_k(k);
        model_clear();
        cycle();
    endtask

    task automatic meas_off();
        meas_en = 1'b0;
        m_on = 1'b0;
        model_clear();
        cycle();
    endtask

    task automatic check_drained(input string name);
        n_total++;
        if (exp_q.size() != 0) $display("FAIL %s got %0d pending publishes exp 0", name, exp_q.size());
        else n_pass++;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; meas_en = 1'b0; sym_clk_ena = 1'b0; log2_win = 5'd4;
        recovered_i = '0; recovered_q = '0; syms_i = '0; syms_q = '0;
        filt_out_i = '0; filt_out_q = '0;
        cycle();
        cycle();
        m_on = 1'b0; m_ref_i = 1460; m_ref_q = 1460; m_wc = 0; model_clear();
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_total++; if (measured_ref_i !== 18'sd1460) $display("FAIL rst_ref_i got %0d exp 1460", measured_ref_i); else n_pass++;
        n_total++; if (measured_ref_q !== 18'sd1460) $display("FAIL rst_ref_q got %0d exp 1460", measured_ref_q); else n_pass++;
        n_total++; if (accumulated_square_error_i !== '0) $display("FAIL rst_err_i got %0d exp 0", accumulated_square_error_i); else n_pass++;
        n_total++; if (meas_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", meas_valid); else n_pass++;
        n_total++; if (window_count !== 16'd0) $display("FAIL rst_wc got %0d exp 0", window_count); else n_pass++;
        n_total++; if (mapper_output_power_i !== '0) $display("FAIL rst_pwr got %0d exp 0", mapper_output_power_i); else n_pass++;
        n_total++; if (o_dbg_state !== 2'd0) $display("FAIL rst_state got %0d exp 0", o_dbg_state); else n_pass++;
        reset_n = 1'b1;
        cycle();
        cycle();
        n_total++; if (mapper_output_power_i !== 37'd2664500) $display("FAIL init_pwr_i got %0d exp 2664500", mapper_output_power_i); else n_pass++;
        n_total++; if (mapper_output_power_q !== 37'd2664500) $display("FAIL init_pwr_q got %0d exp 2664500", mapper_output_power_q); else n_pass++;
    endtask

    task automatic test_level();
        enable(4);
        n_total++; if (o_dbg_state !== 2'd1) $display("FAIL lvl_acq_state got %0d exp 1", o_dbg_state); else n_pass++;
        for (int n = 0; n < 16; n++)
            do_strobe(1000, -500, $urandom_range(3, 0), $urandom_range(3, 0),
                      $urandom_range(2000, 0) - 1000, $urandom_range(2000, 0) - 1000, 1'b0);
        check_drained("lvl_drain");
        n_total++; if (measured_ref_i !== 18'sd1000) $display("FAIL lvl_ref_i got %0d exp 1000", measured_ref_i); else n_pass++;
        n_total++; if (measured_ref_q !== 18'sd500) $display("FAIL lvl_ref_q got %0d exp 500", measured_ref_q); else n_pass++;
        n_total++; if (window_count !== 16'd1) $display("FAIL lvl_wc got %0d exp 1", window_count); else n_pass++;
        n_total++; if (mapper_output_power_i !== 37'd2664500) $display("FAIL lvl_pwr_lag got %0d exp 2664500", mapper_output_power_i); else n_pass++;
        cycle();
        n_total++; if (meas_valid !== 1'b0) $display("FAIL lvl_valid_drop got %b exp 0", meas_valid); else n_pass++;
        n_total++; if (mapper_output_power_i !== 37'd1250000) $display("FAIL lvl_pwr_i got %0d exp 1250000", mapper_output_power_i); else n_pass++;
        n_total++; if (mapper_output_power_q !== 37'd312500) $display("FAIL lvl_pwr_q got %0d exp 312500", mapper_output_power_q); else n_pass++;
    endtask

    task automatic test_error();
        for (int n = 0; n < 16; n++)
            do_strobe(1000, -500, 3, $urandom_range(3, 0), 1510, $urandom_range(1000, 0) - 500, 1'b0);
        check_drained("err_drain_a");
        n_total++; if (accumulated_square_error_i !== 58'd1600) $display("FAIL err_1600 got %0d exp 1600", accumulated_square_error_i); else n_pass++;
        for (int n = 0; n < 16; n++)
            do_strobe(1000, -500, 3, $urandom_range(3, 0), 1500, $urandom_range(1000, 0) - 500, 1'b0);
        check_drained("err_drain_b");
        n_total++; if (accumulated_square_error_i !== 58'd0) $display("FAIL err_zero got %0d exp 0", accumulated_square_error_i); else n_pass++;
    endtask

    task automatic test_saturation();
        meas_off();
        enable(2);
        for (int n = 0; n < 4; n++)
            do_strobe(-131072, 2000, $urandom_range(3, 0), $urandom_range(3, 0), 0, 0, 1'b0);
        check_drained("sat_drain");
        n_total++; if (measured_ref_i !== 18'sd131071) $display("FAIL sat_ref_i got %0d exp 131071", measured_ref_i); else n_pass++;
        n_total++; if (measured_ref_q !== 18'sd2000) $display("FAIL sat_ref_q got %0d exp 2000", measured_ref_q); else n_pass++;
    endtask

    task automatic test_window_change();
        int wc_before;
        meas_off();
        enable(4);
        for (int n = 0; n < 5; n++) rand_strobe(1);
        log2_win = 5'd6;
        for (int n = 5; n < 16; n++) rand_strobe(1);
        check_drained("wchg_first_drain");
        wc_before = m_wc;
        for (int n = 0; n < 63; n++) rand_strobe(2);
        n_total++; if (window_count !== 16'(wc_before)) $display("FAIL wchg_early got wc %0d exp %0d", window_count, wc_before); else n_pass++;
        rand_strobe(0);
        check_drained("wchg_64_drain");
    endtask

    task automatic test_abort();
        meas_off();
        enable(4);
        for (int n = 0; n < 9; n++) rand_strobe(1);
        do_strobe(700, 700, 0, 0, 0, 0, 1'b1);
        n_total++; if (o_dbg_state !== 2'd0) $display("FAIL abort_state got %0d exp 0", o_dbg_state); else n_pass++;
        for (int n = 0; n < 8; n++) rand_strobe(0);
        n_total++; if (measured_ref_i !== DW'(m_ref_i)) $display("FAIL abort_ref_i got %0d exp %0d", measured_ref_i, m_ref_i); else n_pass++;
        n_total++; if (window_count !== 16'(m_wc)) $display("FAIL abort_wc got %0d exp %0d", window_count, m_wc); else n_pass++;
        enable(4);
        for (int n = 0; n < 16; n++) rand_strobe(1);
        check_drained("abort_fresh_drain");
        for (int n = 0; n < 15; n++) rand_strobe(0);
        do_strobe(900, 900, 3, 3, 0, 0, 1'b1);
        cycle();
        n_total++; if (window_count !== 16'(m_wc)) $display("FAIL collide_wc got %0d exp %0d", window_count, m_wc); else n_pass++;
        n_total++; if (o_dbg_state !== 2'd0) $display("FAIL collide_state got %0d exp 0", o_dbg_state); else n_pass++;
    endtask

    task automatic test_back_to_back();
        enable(3);
        for (int n = 0; n < 40; n++) rand_strobe(0);
        check_drained("b2b_drain");
        n_total++; if (o_dbg_state !== 2'd2) $display("FAIL b2b_state got %0d exp 2", o_dbg_state); else n_pass++;
        cycle();
        n_total++; if (mapper_output_power_i !== PW'(pwr(m_ref_i))) $display("FAIL b2b_pwr_i got %0d exp %0d", mapper_output_power_i, pwr(m_ref_i)); else n_pass++;
        n_total++; if (mapper_output_power_q !== PW'(pwr(m_ref_q))) $display("FAIL b2b_pwr_q got %0d exp %0d", mapper_output_power_q, pwr(m_ref_q)); else n_pass++;
    endtask

    task automatic test_clamp();
        meas_off();
        enable(0);
        for (int n = 0; n < 8; n++) rand_strobe(1);
        check_drained("clamp_lo_drain");
        meas_off();
        enable(31);
        for (int n = 0; n < 300; n++) rand_strobe(0);
        n_total++; if (o_dbg_state !== 2'd1) $display("FAIL clamp_hi_state got %0d exp 1", o_dbg_state); else n_pass++;
        n_total++; if (window_count !== 16'(m_wc)) $display("FAIL clamp_hi_wc got %0d exp %0d", window_count, m_wc); else n_pass++;
        meas_off();
    endtask

    task automatic test_reset_mid();
        enable(4);
        for (int n = 0; n < 7; n++) rand_strobe(0);
        apply_reset();
        reset_n = 1'b1;
        n_total++; if (measured_ref_i !== 18'sd1460) $display("FAIL rmid_ref_i got %0d exp 1460", measured_ref_i); else n_pass++;
        n_total++; if (window_count !== 16'd0) $display("FAIL rmid_wc got %0d exp 0", window_count); else n_pass++;
        n_total++; if (accumulated_square_error_q !== '0) $display("FAIL rmid_err_q got %0d exp 0", accumulated_square_error_q); else n_pass++;
        n_total++; if (o_dbg_state !== 2'd0) $display("FAIL rmid_state got %0d exp 0", o_dbg_state); else n_pass++;
        enable(4);
        for (int n = 0; n < 16; n++) rand_strobe(1);
        check_drained("rmid_fresh_drain");
        n_total++; if (window_count !== 16'd1) $display("FAIL rmid_fresh_wc got %0d exp 1", window_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_level();
        test_error();
        test_saturation();
        test_window_change();
        test_abort();
        test_back_to_back();
        test_clamp();
        test_reset_mid();
        repeat (3) cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
